cp0_reg: RTL and testbench
==========================

# cp0_reg

Coprocessor-0 register file for the 5-stage MIPS pipeline. It sits directly downstream of the MEM stage and consumes that stage's `mtc0` write port and its final exception decision: trap type, PC, delay-slot flag and fault address. It owns BadVAddr, Count, Compare, Status, Cause and EPC. It feeds Status, Cause, EPC, BadVAddr and `timer_int` back to MEM for interrupt and `eret` resolution, and provides a read port for `mfc0`.

## Interface
Parameters:
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).
- INT_W, 6, number of hardware interrupt lines.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- int_i  in  INT_W  external interrupt levels, unregistered.
- cp0_we  in  1  `mtc0` write strobe from MEM (already suppressed on exception).
- cp0_waddr  in  5  write register number.
- cp0_wsel  in  3  write select.
- cp0_wdata  in  32  write data.
- raddr  in  5  `mfc0` read register.
- rsel  in  3  `mfc0` read select.
- rdata  out  32  combinational read data; 0 for unimplemented registers.
- exc_type  in  5  final MEM exception code; 0 means none.
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a delay slot.
- exc_badvaddr  in  32  fault address.
- cp0_status, cp0_cause, cp0_epc, cp0_badvaddr  out  32 each  live register values.
- timer_int  out  1  equals Cause.TI.

## Operation
- Register map, all sel 0: BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14.
- Software-writable bits:
  - Status: IM[15:8], EXL[1], IE[0]. All other Status bits hold their reset value.
  - Cause: IP[9:8] only.
  - EPC and Compare: full 32 bits.
  - Count: full 32 bits.
  - BadVAddr: read-only.
- Cause.IP[15:10] is resampled every cycle:
  - IP[15] = int_i[5] | TI.
  - IP[14:10] = int_i[4:0].
- Exception commit, when exc_type ≠ 0 and ≠ EXC_ERET, at the clock edge:
  - If Status.EXL == 0: EPC ← exc_bd ? exc_pc−4 : exc_pc, and Cause.BD ← exc_bd.
  - If Status.EXL == 1: EPC and BD are unchanged.
  - Cause.ExcCode[6:2] ← (exc_type == EXC_INT) ? 0 : exc_type.
  - Status.EXL ← 1.
  - For EXC_ADEL or EXC_ADES only: BadVAddr ← exc_badvaddr.
- `eret` (exc_type == EXC_ERET): Status.EXL ← 0. Nothing else changes.
- Priority within one edge: exception/eret > `mtc0`.
  - A concurrent cp0_we is ignored.
  - Hardware-owned fields (IP[15:10], TI, Count increment) always update.
- Timer:
  - A 1-bit `tick` toggles every cycle; Count increments when tick == 1, i.e. every 2 cycles.
  - A Count write loads cp0_wdata, clears tick, and overrides the increment.
  - TI is set on any edge where Count == Compare and Compare is not being written.
  - A Compare write clears TI; the write has priority over a simultaneous match.
  - Count wraps from FFFF_FFFF to 0 with no side effect.
- Read port is combinational from current register state. There is no write-to-read bypass.

## Timing
- Reset values:
  - Status = STATUS_RST.
  - Count, Compare, Cause, EPC, BadVAddr, tick, and timer_int are all 0.
  - rdata follows raddr.
- `mtc0` and exception updates are visible on the outputs 1 cycle after the edge that samples them.
- The MEM flush is asserted in the cycle before that edge. The first instruction fetched from the handler therefore sees EXL=1.
- int_i to Cause.IP: 1 cycle of latency.
- TI to timer_int: 0 cycles (combinational from the TI bit).
- Reset mid-operation: the reset edge overrides every pending write, exception and increment.

## Configuration
- CP0_COUNT_EN defined:
  - Count, Compare, tick and TI are implemented as described above.
- CP0_COUNT_EN undefined:
  - Count and Compare read 0, and writes to them are ignored.
  - TI stays 0 and timer_int = 0.
  - IP[15] = int_i[5].

## Structure
- defines.vh holds the following, consumed alongside MEM:
  - internal exception codes: EXC_INT 5'h01, EXC_ADEL 5'h04, EXC_ADES 5'h05, EXC_SYS 5'h08, EXC_BP 5'h09, EXC_RI 5'h0a, EXC_OV 5'h0c, EXC_ERET 5'h0e;
  - CP0 register numbers;
  - writable-bit masks.
- One sub-module, `cp0_timer`: Count, Compare, tick and TI, with a Count/Compare write interface. It is instantiated only under CP0_COUNT_EN.

## Test plan
- Reset, then read Status → 0x0040_0000. All other registers read 0 and timer_int = 0.
- `mtc0` Status ← 0xFFFF_FFFF → reads 0x0040_FF03. `mtc0` Cause ← 0xFFFF_FFFF → reads 0x0000_0300.
- exc_type=EXC_ADEL, exc_pc=0xBFC0_1004, exc_bd=1, exc_badvaddr=0x8000_0002, with EXL=0 → next cycle:
  - EPC = 0xBFC0_1000;
  - Cause = 0x8000_0010;
  - BadVAddr = 0x8000_0002;
  - EXL = 1.
  Then EXC_SYS with exc_pc=0x1234 → EPC unchanged and ExcCode = 0x08. Then EXC_ERET → EXL = 0.
- Compare ← 6, Count ← 0 → Count reaches 6 after 12 cycles and timer_int rises. Compare ← 6 again → timer_int = 0 on the next cycle.
- Exception and cp0_we to EPC (0xDEAD_BEEF) on the same edge → EPC equals the exception-derived value.
- int_i = 6'b100000 with CP0_COUNT_EN undefined → Cause[15] = 1 after 1 cycle. Count still reads 0.

Source files
------------

// File: rtl/cp0_reg_pkg.sv
// Shared CP0 definitions: exception codes, register numbers, writable masks and the Cause layout.
// Consumed by cp0_reg, cp0_timer and the MEM-stage exception logic.
package cp0_reg_pkg;

  // Internal exception codes carried on exc_type; 0 means no exception.
  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // CP0 register numbers (all at select 0).
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // Software-writable bits.
  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  localparam int ST_EXL = 1;

  typedef struct packed {
    logic        bd;
    logic        ti;
    logic [13:0] rsv_hi;
    logic [5:0]  ip_hw;
    logic [1:0]  ip_sw;
    logic        rsv_mid;
    logic [4:0]  exc_code;
    logic [1:0]  rsv_lo;
  } cause_t;

  // A faulting delay-slot instruction restarts at its branch.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  // Interrupts report ExcCode 0; every other trap reports its own code.
  function automatic logic [4:0] exc_code_of(input logic [4:0] exc);
    logic [4:0] code;
    case (exc)
      EXC_INT:                                       code = 5'h00;
      EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV: code = exc;
      default:                                       code = exc;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI latches on Count == Compare.
// Only instantiated by cp0_reg when CP0_COUNT_EN is defined.
module cp0_timer
  import cp0_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (count_we) begin
      count <= wdata;
      tick  <= 1'b0;
    end else begin
      count <= count + {31'd0, tick};
      tick  <= ~tick;
    end
  end

  // A Compare write acknowledges the interrupt and wins over a same-edge match.
  always_ff @(posedge clk) begin
    if (rst) begin
      compare <= '0;
      ti      <= 1'b0;
    end else if (compare_we) begin
      compare <= wdata;
      ti      <= 1'b0;
    end else if (count == compare) begin
      ti      <= 1'b1;
    end
  end

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, mtc0/mfc0 ports.
// Define CP0_COUNT_EN to build the Count/Compare timer; otherwise they read 0 and TI stays low.
module cp0_reg
  import cp0_reg_pkg::*;
#(
  parameter logic [31:0] STATUS_RST = 32'h0040_0000,
  parameter int          INT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INT_W-1:0] int_i,
  input  logic             cp0_we,
  input  logic [4:0]       cp0_waddr,
  input  logic [2:0]       cp0_wsel,
  input  logic [31:0]      cp0_wdata,
  input  logic [4:0]       raddr,
  input  logic [2:0]       rsel,
  output logic [31:0]      rdata,
  input  logic [4:0]       exc_type,
  input  logic [31:0]      exc_pc,
  input  logic             exc_bd,
  input  logic [31:0]      exc_badvaddr,
  output logic [31:0]      cp0_status,
  output logic [31:0]      cp0_cause,
  output logic [31:0]      cp0_epc,
  output logic [31:0]      cp0_badvaddr,
  output logic             timer_int
);

  logic        exc_take;
  logic        eret_take;
  logic        mtc0_ok;
  logic        we_status;
  logic        we_cause;
  logic        we_epc;
  logic [5:0]  int_hw;

  logic [31:0] status_q;
  logic [31:0] epc_q;
  logic [31:0] badvaddr_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_hw_q;
  logic [1:0]  cause_ip_sw_q;
  logic [4:0]  cause_exc_q;
  cause_t      cause_v;

  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  // Exceptions and eret both block a same-edge mtc0.
  assign exc_take  = (exc_type != EXC_NONE) && (exc_type != EXC_ERET);
  assign eret_take = (exc_type == EXC_ERET);
  assign mtc0_ok   = cp0_we && (exc_type == EXC_NONE) && (cp0_wsel == 3'd0);
  assign we_status = mtc0_ok && (cp0_waddr == CP0_STATUS);
  assign we_cause  = mtc0_ok && (cp0_waddr == CP0_CAUSE);
  assign we_epc    = mtc0_ok && (cp0_waddr == CP0_EPC);
  assign int_hw    = 6'(int_i);

`ifdef CP0_COUNT_EN
  logic we_count;
  logic we_compare;

  assign we_count   = mtc0_ok && (cp0_waddr == CP0_COUNT);
  assign we_compare = mtc0_ok && (cp0_waddr == CP0_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_count),
    .compare_we (we_compare),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
    end else if (exc_take) begin
      status_q[ST_EXL] <= 1'b1;
    end else if (eret_take) begin
      status_q[ST_EXL] <= 1'b0;
    end else if (we_status) begin
      status_q <= (cp0_wdata & STATUS_WMASK) | (STATUS_RST & ~STATUS_WMASK);
    end
  end

  // Nested exceptions (EXL already set) keep the original BD and EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_bd_q    <= 1'b0;
      cause_ip_hw_q <= '0;
      cause_ip_sw_q <= '0;
      cause_exc_q   <= '0;
    end else begin
      cause_ip_hw_q <= {int_hw[5] | ti, int_hw[4:0]};
      if (exc_take) begin
        if (!status_q[ST_EXL]) begin
          cause_bd_q <= exc_bd;
        end
        cause_exc_q <= exc_code_of(exc_type);
      end else if (we_cause) begin
        cause_ip_sw_q <= cp0_wdata[9:8] & CAUSE_WMASK[9:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      epc_q <= '0;
    end else if (exc_take && !status_q[ST_EXL]) begin
      epc_q <= epc_of(exc_pc, exc_bd);
    end else if (we_epc) begin
      epc_q <= cp0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q <= '0;
    end else if (exc_take && ((exc_type == EXC_ADEL) || (exc_type == EXC_ADES))) begin
      badvaddr_q <= exc_badvaddr;
    end
  end

  always_comb begin
    cause_v          = '0;
    cause_v.bd       = cause_bd_q;
    cause_v.ti       = ti;
    cause_v.ip_hw    = cause_ip_hw_q;
    cause_v.ip_sw    = cause_ip_sw_q;
    cause_v.exc_code = cause_exc_q;
  end

  assign cp0_status   = status_q;
  assign cp0_cause    = cause_v;
  assign cp0_epc      = epc_q;
  assign cp0_badvaddr = badvaddr_q;
  assign timer_int    = ti;

  always_comb begin
    rdata = '0;
    if (rsel == 3'd0) begin
      case (raddr)
        CP0_BADVADDR: rdata = badvaddr_q;
        CP0_COUNT:    rdata = count;
        CP0_COMPARE:  rdata = compare;
        CP0_STATUS:   rdata = status_q;
        CP0_CAUSE:    rdata = cause_v;
        CP0_EPC:      rdata = epc_q;
        default:      rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: directed scenarios plus random traffic against a cycle model.
// Model honours CP0_COUNT_EN the same way the design does.
module tb_cp0_reg;

  localparam logic [31:0] ST_RST = 32'h0040_0000;
  localparam logic [4:0] E_INT = 5'h01, E_ADEL = 5'h04, E_ADES = 5'h05, E_SYS = 5'h08;
  localparam logic [4:0] E_BP = 5'h09, E_RI = 5'h0a, E_OV = 5'h0c, E_ERET = 5'h0e;
`ifdef CP0_COUNT_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  int_i;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [2:0]  cp0_wsel;
  logic [31:0] cp0_wdata;
  logic [4:0]  raddr;
  logic [2:0]  rsel;
  logic [31:0] rdata;
  logic [4:0]  exc_type;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic [31:0] exc_badvaddr;
  logic [31:0] cp0_status, cp0_cause, cp0_epc, cp0_badvaddr;
  logic        timer_int;

  always #5 clk = ~clk;

  cp0_reg dut (
    .clk(clk), .rst(rst), .int_i(int_i),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wsel(cp0_wsel), .cp0_wdata(cp0_wdata),
    .raddr(raddr), .rsel(rsel), .rdata(rdata),
    .exc_type(exc_type), .exc_pc(exc_pc), .exc_bd(exc_bd), .exc_badvaddr(exc_badvaddr),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .cp0_badvaddr(cp0_badvaddr), .timer_int(timer_int)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Architectural state of the reference model.
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
  logic        m_bd, m_ti, m_tick;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_exc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return (32'(m_bd) << 31) | (32'(m_ti) << 30) | (32'(m_iphw) << 10) |
           (32'(m_ipsw) << 8) | (32'(m_exc) << 2);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [2:0] s);
    if (s != 3'd0) return 32'd0;
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_status = ST_RST; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
    m_bd = 0; m_ti = 0; m_tick = 0; m_iphw = 0; m_ipsw = 0; m_exc = 0;
  endtask

  // Next-state of the whole register file for the inputs currently applied.
  task automatic model_step();
    bit trap, ret, wr, wr_cnt, wr_cmp, old_exl;
    logic [31:0] n_count, n_compare;
    bit n_ti, n_tick;
    if (rst) begin
      model_reset();
      return;
    end
    trap    = (exc_type != 0) && (exc_type != E_ERET);
    ret     = (exc_type == E_ERET);
    wr      = cp0_we && (exc_type == 0) && (cp0_wsel == 0);
    wr_cnt  = wr && cp0_waddr == 9;
    wr_cmp  = wr && cp0_waddr == 11;
    old_exl = m_status[1];
    n_count = m_count; n_compare = m_compare; n_ti = m_ti; n_tick = m_tick;
    if (TIMER) begin
      n_count   = wr_cnt ? cp0_wdata : m_count + (m_tick ? 32'd1 : 32'd0);
      n_tick    = wr_cnt ? 1'b0 : !m_tick;
      n_compare = wr_cmp ? cp0_wdata : m_compare;
      n_ti      = wr_cmp ? 1'b0 : ((m_count == m_compare) ? 1'b1 : m_ti);
    end
    m_iphw = {int_i[5] | m_ti, int_i[4:0]};
    if (trap) begin
      if (!old_exl) begin
        m_epc = exc_bd ? exc_pc - 4 : exc_pc;
        m_bd  = exc_bd;
      end
      m_exc = (exc_type == E_INT) ? 5'd0 : exc_type;
      m_status[1] = 1'b1;
      if (exc_type == E_ADEL || exc_type == E_ADES) m_bad = exc_badvaddr;
    end else if (ret) begin
      m_status[1] = 1'b0;
    end else if (wr) begin
      case (cp0_waddr)
        5'd12:   m_status = (cp0_wdata & 32'h0000_ff03) | (ST_RST & ~32'h0000_ff03);
        5'd13:   m_ipsw = cp0_wdata[9:8];
        5'd14:   m_epc = cp0_wdata;
        default: ;
      endcase
    end
    m_count = n_count; m_compare = n_compare; m_ti = n_ti; m_tick = n_tick;
  endtask

  task automatic check_all();
    chk("status", cp0_status, m_status);
    chk("cause", cp0_cause, m_cause());
    chk("epc", cp0_epc, m_epc);
    chk("badvaddr", cp0_badvaddr, m_bad);
    chk("timer_int", 32'(timer_int), 32'(m_ti));
    chk("rdata", rdata, m_read(raddr, rsel));
  endtask

  task automatic idle();
    rst = 0; int_i = 0; cp0_we = 0; cp0_waddr = 0; cp0_wsel = 0; cp0_wdata = 0;
    exc_type = 0; exc_pc = 0; exc_bd = 0; exc_badvaddr = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
    step();
    idle();
  endtask

  task automatic trap(input logic [4:0] t, input logic [31:0] pc, input logic bd,
                      input logic [31:0] bad);
    idle(); exc_type = t; exc_pc = pc; exc_bd = bd; exc_badvaddr = bad;
    step();
    idle();
  endtask

  initial begin
    logic [4:0] codes [8];
    logic [4:0] addrs [8];
    codes = '{E_INT, E_ADEL, E_ADES, E_SYS, E_BP, E_RI, E_OV, E_ERET};
    addrs = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd15};
    idle(); raddr = 5'd12; rsel = 0;
    rst = 1; step(); step(); rst = 0;

    // reset state, read port combinational over every register
    chk("rst_status", cp0_status, 32'h0040_0000);
    chk("rst_cause", cp0_cause, 32'h0);
    chk("rst_epc", cp0_epc, 32'h0);
    chk("rst_badvaddr", cp0_badvaddr, 32'h0);
    chk("rst_timer_int", 32'(timer_int), 32'h0);
    for (int i = 0; i < 8; i++) begin
      raddr = addrs[i]; #1;
      chk("rst_rdata", rdata, (addrs[i] == 5'd12) ? 32'h0040_0000 : 32'h0);
    end

    raddr = 5'd12;
    mtc0(5'd12, 32'hffff_ffff);
    chk("status_wmask", rdata, 32'h0040_ff03);
    raddr = 5'd13;
    mtc0(5'd13, 32'hffff_ffff);
    chk("cause_wmask", cp0_cause & 32'h0000_03ff, 32'h0000_0300);
    mtc0(5'd12, 32'h0);

    trap(E_ADEL, 32'hbfc0_1004, 1'b1, 32'h8000_0002);
    chk("adel_epc", cp0_epc, 32'hbfc0_1000);
    chk("adel_cause", cp0_cause & 32'h8000_007c, 32'h8000_0010);
    chk("adel_badvaddr", cp0_badvaddr, 32'h8000_0002);
    chk("adel_exl", 32'(cp0_status[1]), 32'h1);
    trap(E_SYS, 32'h0000_1234, 1'b0, 32'h0);
    chk("nested_epc", cp0_epc, 32'hbfc0_1000);
    chk("nested_code", 32'(cp0_cause[6:2]), 32'h08);
    trap(E_ERET, 32'h0, 1'b0, 32'h0);
    chk("eret_exl", 32'(cp0_status[1]), 32'h0);

    idle(); exc_type = E_SYS; exc_pc = 32'h0000_2000;
    cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hdead_beef;
    step(); idle();
    chk("exc_over_mtc0", cp0_epc, 32'h0000_2000);
    trap(E_ERET, 32'h0, 1'b0, 32'h0);

    raddr = 5'd9;
    int_i = 6'b100000; step(); int_i = 0;
    chk("int5_ip15", 32'(cp0_cause[15]), 32'h1);
`ifndef CP0_COUNT_EN
    chk("count_absent", rdata, 32'h0);
    mtc0(5'd9, 32'h1234_5678);
    chk("count_wr_ignored", rdata, 32'h0);
`else
    rst = 1; step(); rst = 0;
    mtc0(5'd11, 32'd6);
    mtc0(5'd9, 32'd0);
    for (int i = 0; i < 12; i++) step();
    chk("count_at_12", rdata, 32'd6);
    chk("ti_not_yet", 32'(timer_int), 32'h0);
    step();
    chk("ti_rise", 32'(timer_int), 32'h1);
    mtc0(5'd11, 32'd6);
    chk("ti_clear", 32'(timer_int), 32'h0);
    mtc0(5'd9, 32'hffff_ffff);
    step(); step();
    chk("count_wrap", rdata, 32'h0);
`endif

    // reset beats a concurrent exception and write
    idle(); rst = 1; exc_type = E_ADES; exc_badvaddr = 32'h55aa_55aa;
    cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'hffff_ffff;
    step(); idle();
    chk("midrst_status", cp0_status, 32'h0040_0000);
    chk("midrst_badvaddr", cp0_badvaddr, 32'h0);

    for (int c = 0; c < 800; c++) begin
      idle();
      int_i = 6'($urandom);
      raddr = addrs[$urandom_range(0, 7)];
      rsel  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd0;
      if ($urandom_range(0, 2) == 0) begin
        cp0_we    = 1;
        cp0_waddr = addrs[$urandom_range(0, 7)];
        cp0_wsel  = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0;
        cp0_wdata = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      end
      if ($urandom_range(0, 6) == 0) begin
        exc_type     = codes[$urandom_range(0, 7)];
        exc_pc       = {$urandom} & 32'hffff_fffc;
        exc_bd       = 1'($urandom);
        exc_badvaddr = $urandom;
      end
      rst = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
